// File: rtl/uart_bus_pkg.sv
// Shared register map, bit positions and TX state encoding for the 6502-side UART bridge.
package uart_bus_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_RXNE = 0;
  localparam int STAT_TXNF = 1;
  localparam int STAT_OVR  = 2;
  localparam int STAT_BUSY = 3;
  localparam int STAT_IRQ  = 7;

  localparam int CTRL_RXIE = 0;
  localparam int CTRL_TXIE = 1;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// 8-bit synchronous FIFO clocked on the falling edge; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(negedge clk) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; count and pointers
  // already guarantee stale entries are never observed.
  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// CPU-facing register front end for the UART core: TX/RX byte FIFOs,
// status/control registers, TX handshake FSM and a level interrupt.
module uart_bus_bridge
  import uart_bus_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       bus_en,
  input  logic       bus_rw,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       irq_n,
  output logic       uart_tx_write,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_finished,
  input  logic       uart_rx_ready,
  input  logic [7:0] uart_rx_data
);

  logic data_rd, data_wr, stat_wr, ctrl_wr;

  logic [7:0]          rx_head, tx_head;
  logic                rx_empty, rx_full, tx_empty, tx_full;
  logic [DEPTH_LOG2:0] rx_count, tx_count;

  logic       overrun;
  logic [1:0] ctrl;
  logic       tx_pop, tx_busy, irq_term;

  tx_state_e state, state_next;

  assign data_rd = bus_en &  bus_rw & (bus_addr == REG_DATA);
  assign data_wr = bus_en & ~bus_rw & (bus_addr == REG_DATA);
  assign stat_wr = bus_en & ~bus_rw & (bus_addr == REG_STATUS);
  assign ctrl_wr = bus_en & ~bus_rw & (bus_addr == REG_CTRL);

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (uart_rx_ready),
    .pop     (data_rd),
    .din     (uart_rx_data),
    .dout    (rx_head),
    .empty   (rx_empty),
    .full    (rx_full),
    .count   (rx_count)
  );

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (data_wr),
    .pop     (tx_pop),
    .din     (bus_din),
    .dout    (tx_head),
    .empty   (tx_empty),
    .full    (tx_full),
    .count   (tx_count)
  );

  // Occupancy counts are not needed by the register map.
  logic unused_counts;
  assign unused_counts = ^{rx_count, tx_count};

  // A received byte is lost only when the FIFO is full and the CPU is not
  // freeing a slot on the same edge; a new loss beats a simultaneous clear.
  always_ff @(negedge clk) begin
    if (!n_reset) begin
      overrun <= 1'b0;
    end else if (uart_rx_ready && rx_full && !data_rd) begin
      overrun <= 1'b1;
    end else if (stat_wr && bus_din[STAT_OVR]) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (!n_reset) begin
      ctrl <= 2'b00;
    end else if (ctrl_wr) begin
      ctrl <= {bus_din[CTRL_TXIE], bus_din[CTRL_RXIE]};
    end
  end

  // NOTE: combinational outputs get a default before any branch so no path
  // leaves them unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    tx_pop     = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          state_next = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (uart_tx_finished) state_next = TX_IDLE;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (!n_reset) begin
      state         <= TX_IDLE;
      uart_tx_write <= 1'b0;
      uart_tx_data  <= 8'h00;
    end else begin
      state         <= state_next;
      uart_tx_write <= tx_pop;
      if (tx_pop) uart_tx_data <= tx_head;
    end
  end

  assign tx_busy  = (state != TX_IDLE) | ~tx_empty;
  assign irq_term = (ctrl[CTRL_RXIE] & (~rx_empty | overrun)) |
                    (ctrl[CTRL_TXIE] & ~tx_busy);

  always_ff @(negedge clk) begin
    if (!n_reset) begin
      irq_n <= 1'b1;
    end else begin
      irq_n <= ~irq_term;
    end
  end

  always_comb begin
    bus_dout = 8'h00;
    case (bus_addr)
      REG_DATA: begin
        if (!rx_empty) bus_dout = rx_head;
      end
      REG_STATUS: begin
        bus_dout[STAT_RXNE] = ~rx_empty;
        bus_dout[STAT_TXNF] = ~tx_full;
        bus_dout[STAT_OVR]  = overrun;
        bus_dout[STAT_BUSY] = tx_busy;
        bus_dout[STAT_IRQ]  = irq_term;
      end
      REG_CTRL: begin
        bus_dout[CTRL_RXIE] = ctrl[CTRL_RXIE];
        bus_dout[CTRL_TXIE] = ctrl[CTRL_TXIE];
      end
      default: bus_dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: a register/IRQ vector table plus
// hand-written TX handshake, RX overflow and mid-transfer reset sequences.
module tb_uart_bus_bridge;
  import uart_bus_pkg::*;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       bus_en = 1'b0;
  logic       bus_rw = 1'b0;
  logic [1:0] bus_addr = 2'd0;
  logic [7:0] bus_din = 8'h00;
  logic [7:0] bus_dout;
  logic       irq_n;
  logic       uart_tx_write;
  logic [7:0] uart_tx_data;
  logic       uart_tx_finished = 1'b0;
  logic       uart_rx_ready = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;

  int checks = 0;
  int errors = 0;

  uart_bus_bridge #(.DEPTH_LOG2(4)) dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .bus_en           (bus_en),
    .bus_rw           (bus_rw),
    .bus_addr         (bus_addr),
    .bus_din          (bus_din),
    .bus_dout         (bus_dout),
    .irq_n            (irq_n),
    .uart_tx_write    (uart_tx_write),
    .uart_tx_data     (uart_tx_data),
    .uart_tx_finished (uart_tx_finished),
    .uart_rx_ready    (uart_rx_ready),
    .uart_rx_data     (uart_rx_data)
  );

  always #5 clk = ~clk;

  // UART TX model: logs each start pulse and answers with finished 20 cycles
  // later when auto_finish is set; fin_req != fin_ack requests one manual pulse.
  int         cyc = 0;
  int         pulse_cnt = 0;
  int         fin_done = 0;
  int         fin_cnt = 0;
  int         fin_req = 0;
  int         fin_ack = 0;
  bit         auto_finish = 1'b0;
  bit         hold_bad = 1'b0;
  bit         width_bad = 1'b0;
  logic       prev_write = 1'b0;
  int         pulse_cyc [16];
  int         fin_cyc [16];
  logic [7:0] pulse_data [16];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      uart_tx_finished = 1'b0;
      if (fin_req != fin_ack) begin
        fin_ack = fin_req;
        uart_tx_finished = 1'b1;
        fin_cyc[fin_done % 16] = cyc;
        fin_done++;
      end else if (fin_cnt > 0) begin
        if (uart_tx_data !== pulse_data[(pulse_cnt - 1) % 16]) hold_bad = 1'b1;
        fin_cnt--;
        if (fin_cnt == 0) begin
          uart_tx_finished = 1'b1;
          fin_cyc[fin_done % 16] = cyc;
          fin_done++;
        end
      end
      if (uart_tx_write === 1'b1) begin
        if (prev_write === 1'b1) width_bad = 1'b1;
        pulse_data[pulse_cnt % 16] = uart_tx_data;
        pulse_cyc[pulse_cnt % 16]  = cyc;
        pulse_cnt++;
        if (auto_finish) fin_cnt = 20;
      end
      prev_write = uart_tx_write;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk);
    bus_en = 1'b1; bus_rw = 1'b0; bus_addr = a; bus_din = d;
    @(posedge clk);
    bus_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(posedge clk);
    bus_en = 1'b1; bus_rw = 1'b1; bus_addr = a;
    #1 d = bus_dout;
    @(posedge clk);
    bus_en = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(posedge clk);
    uart_rx_ready = 1'b1; uart_rx_data = d;
    @(posedge clk);
    uart_rx_ready = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] din;
    logic       rx;
    logic [7:0] rxd;
    logic [7:0] exp_dout;
    logic       exp_irq_n;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    logic [7:0] rd;
    int base;

    // en, rw, addr, din, rx_ready, rx_data, expected dout (pre-edge), expected irq_n
    vecs[0]  = '{1'b1, 1'b1, REG_STATUS, 8'h00, 1'b0, 8'h00, 8'h02, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, REG_CTRL,   8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 2'd3,       8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, REG_DATA,   8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, REG_CTRL,   8'h01, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, REG_CTRL,   8'h00, 1'b1, 8'h99, 8'h01, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, REG_STATUS, 8'h00, 1'b0, 8'h00, 8'h83, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, REG_DATA,   8'h00, 1'b0, 8'h00, 8'h99, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, REG_STATUS, 8'h00, 1'b0, 8'h00, 8'h02, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, REG_STATUS, 8'h00, 1'b0, 8'h00, 8'h02, 1'b1};
    vecs[10] = '{1'b1, 1'b0, REG_CTRL,   8'h02, 1'b0, 8'h00, 8'h01, 1'b1};
    vecs[11] = '{1'b0, 1'b0, REG_STATUS, 8'h00, 1'b0, 8'h00, 8'h82, 1'b1};
    vecs[12] = '{1'b0, 1'b0, REG_CTRL,   8'h00, 1'b0, 8'h00, 8'h02, 1'b0};
    vecs[13] = '{1'b1, 1'b0, REG_CTRL,   8'h00, 1'b0, 8'h00, 8'h02, 1'b0};
    vecs[14] = '{1'b0, 1'b0, REG_CTRL,   8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[15] = '{1'b0, 1'b0, REG_STATUS, 8'h00, 1'b0, 8'h00, 8'h02, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 2'd3,       8'hFF, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 2'd3,       8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[18] = '{1'b1, 1'b1, REG_CTRL,   8'h00, 1'b0, 8'h00, 8'h00, 1'b1};

    // Reset
    repeat (3) @(posedge clk);
    n_reset = 1'b1;
    #1;
    check("reset irq_n", irq_n, 1'b1);
    check("reset tx_write", uart_tx_write, 1'b0);
    check("reset tx_data", uart_tx_data, 8'h00);
    check("reset dout DATA", bus_dout, 8'h00);

    // Register map and interrupt timing
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      bus_en = vecs[i].en; bus_rw = vecs[i].rw; bus_addr = vecs[i].addr;
      bus_din = vecs[i].din; uart_rx_ready = vecs[i].rx; uart_rx_data = vecs[i].rxd;
      #1;
      check($sformatf("vec%0d dout", i), bus_dout, vecs[i].exp_dout);
      check($sformatf("vec%0d irq_n", i), irq_n, vecs[i].exp_irq_n);
    end
    @(posedge clk);
    bus_en = 1'b0; uart_rx_ready = 1'b0;
    check("no tx pulse while idle", pulse_cnt, 0);

    // TX handshake
    auto_finish = 1'b1;
    bus_write(REG_DATA, 8'h41);
    #1 check("tx_write not yet", uart_tx_write, 1'b0);
    @(posedge clk);
    #1;
    check("tx_write edge after push", uart_tx_write, 1'b1);
    check("tx_data first", uart_tx_data, 8'h41);
    bus_write(REG_DATA, 8'h42);
    bus_read(REG_STATUS, rd);
    check("status busy", rd, 8'h0A);
    for (int i = 0; i < 200 && fin_done < 2; i++) @(posedge clk);
    check("tx finished count", fin_done, 2);
    check("tx pulse count", pulse_cnt, 2);
    check("tx pulse0 data", pulse_data[0], 8'h41);
    check("tx pulse1 data", pulse_data[1], 8'h42);
    check("tx restart latency", pulse_cyc[1] - fin_cyc[0], 2);
    check("tx_data held in wait", hold_bad, 1'b0);
    check("tx_write single cycle", width_bad, 1'b0);
    repeat (2) @(posedge clk);
    bus_read(REG_STATUS, rd);
    check("status after tx", rd, 8'h02);

    // RX overflow
    for (int i = 0; i < 17; i++) rx_pulse(8'(8'h10 + i));
    bus_read(REG_STATUS, rd);
    check("status overrun", rd, 8'h07);
    for (int i = 0; i < 16; i++) begin
      bus_read(REG_DATA, rd);
      check($sformatf("rx order %0d", i), rd, 8'(8'h10 + i));
    end
    bus_read(REG_STATUS, rd);
    check("status drained ovr kept", rd, 8'h06);
    bus_write(REG_STATUS, 8'h00);
    bus_read(REG_STATUS, rd);
    check("ovr not cleared by 0", rd, 8'h06);
    bus_write(REG_STATUS, 8'h04);
    bus_read(REG_STATUS, rd);
    check("ovr cleared", rd, 8'h02);

    // Full RX FIFO with simultaneous pop and push
    for (int i = 0; i < 16; i++) rx_pulse(8'(8'h60 + i));
    bus_read(REG_STATUS, rd);
    check("status rx full", rd, 8'h03);
    @(posedge clk);
    bus_en = 1'b1; bus_rw = 1'b1; bus_addr = REG_DATA;
    uart_rx_ready = 1'b1; uart_rx_data = 8'h55;
    #1 rd = bus_dout;
    @(posedge clk);
    bus_en = 1'b0; uart_rx_ready = 1'b0;
    check("simul read head", rd, 8'h60);
    bus_read(REG_STATUS, rd);
    check("simul no overrun", rd, 8'h03);
    for (int i = 0; i < 15; i++) begin
      bus_read(REG_DATA, rd);
      check($sformatf("simul order %0d", i), rd, 8'(8'h61 + i));
    end
    bus_read(REG_DATA, rd);
    check("simul last entry", rd, 8'h55);
    bus_read(REG_STATUS, rd);
    check("simul drained", rd, 8'h02);

    // Reset while the TX FSM waits for finished
    auto_finish = 1'b0;
    base = pulse_cnt;
    bus_write(REG_DATA, 8'hA1);
    bus_write(REG_DATA, 8'hA2);
    bus_write(REG_DATA, 8'hA3);
    for (int i = 0; i < 20 && pulse_cnt < base + 1; i++) @(posedge clk);
    check("mid pulse seen", pulse_cnt, base + 1);
    check("mid pulse data", pulse_data[base % 16], 8'hA1);
    @(posedge clk);
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    n_reset = 1'b1;
    #1;
    check("mid reset tx_write", uart_tx_write, 1'b0);
    check("mid reset tx_data", uart_tx_data, 8'h00);
    check("mid reset irq_n", irq_n, 1'b1);
    fin_req++;
    repeat (30) @(posedge clk);
    check("no pulse after reset", pulse_cnt, base + 1);
    bus_read(REG_STATUS, rd);
    check("status after reset", rd, 8'h02);
    bus_read(REG_DATA, rd);
    check("rx empty after reset", rd, 8'h00);
    auto_finish = 1'b1;
    bus_write(REG_DATA, 8'h5A);
    for (int i = 0; i < 20 && pulse_cnt < base + 2; i++) @(posedge clk);
    check("post reset pulse", pulse_cnt, base + 2);
    check("post reset data", pulse_data[(base + 1) % 16], 8'h5A);
    repeat (40) @(posedge clk);
    check("stale bytes discarded", pulse_cnt, base + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
